// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch front end between the PC and decode.
// Issues single-outstanding word reads on a req/gnt/rvalid bus, buffers the
// returned instructions with their addresses in a DEPTH-entry FIFO, and drives
// the PC control code (00 advance, 01 load pc_jump, 10 hold).
// Optional feature: define FETCH_PERF_EN to add the saturating perf_stall and
// perf_flush counter outputs.
module instr_fetch_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          RST,
  input  logic [AW-1:0] IADDR,
  output logic [1:0]    pc_ctrl,
  output logic [AW-1:0] pc_jump,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          instr_valid,
  output logic [31:0]   instr_data,
  output logic [AW-1:0] instr_addr,
`ifdef FETCH_PERF_EN
  output logic [31:0]   perf_stall,
  output logic [31:0]   perf_flush,
`endif
  input  logic          instr_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    FETCH    = 2'b00,
    WAIT_RSP = 2'b01,
    FLUSH    = 2'b10
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [AW-1:0] req_addr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   data_mem_r [DEPTH];
  logic [AW-1:0] addr_mem_r [DEPTH];

  logic          full_s;
  logic          mem_req_s;
  logic [1:0]    pc_ctrl_s;
  logic          push_s;
  logic          pop_s;
  logic          issue_s;

  assign full_s = (count_r == DEPTH_C);
  assign pop_s  = (count_r != {CW{1'b0}}) && instr_ready && !redirect;

  // Next-state, request and PC-control decode; redirect overrides everything.
  always_comb begin
    state_s   = state_r;
    mem_req_s = 1'b0;
    pc_ctrl_s = 2'b10;
    push_s    = 1'b0;
    issue_s   = 1'b0;
    case (state_r)
      FETCH: begin
        mem_req_s = !redirect && !full_s;
        if (mem_req_s && mem_gnt) begin
          pc_ctrl_s = 2'b00;
          issue_s   = 1'b1;
          state_s   = WAIT_RSP;
        end else begin
          pc_ctrl_s = 2'b10;
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid) begin
          push_s  = !redirect;
          state_s = FETCH;
        end else if (redirect) begin
          state_s = FLUSH;
        end else begin
          state_s = WAIT_RSP;
        end
      end
      FLUSH: begin
        // The stale response is dropped; a redirect arriving together with it
        // still returns to FETCH since no further response will follow.
        if (mem_rvalid) begin
          state_s = FETCH;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = FETCH;
      end
    endcase
    if (redirect) begin
      pc_ctrl_s = 2'b01;
      mem_req_s = 1'b0;
      issue_s   = 1'b0;
    end else begin
      pc_ctrl_s = pc_ctrl_s;
    end
  end

  // Outputs toward PC and memory are held inactive while reset is asserted.
  assign mem_req  = RST & mem_req_s;
  assign pc_ctrl  = RST ? pc_ctrl_s : 2'b10;
  assign pc_jump  = RST ? redirect_addr : {AW{1'b0}};
  assign mem_addr = IADDR;

  assign instr_valid = (count_r != {CW{1'b0}});
  assign instr_data  = data_mem_r[rd_ptr_r];
  assign instr_addr  = addr_mem_r[rd_ptr_r];

  // FSM state register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Address of the request in flight, captured on grant.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      req_addr_r <= {AW{1'b0}};
    end else if (issue_s) begin
      req_addr_r <= IADDR;
    end else begin
      req_addr_r <= req_addr_r;
    end
  end

  // FIFO pointers and occupancy; redirect flushes on the same edge.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (redirect) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage: instruction word and its fetch address.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= 32'h0000_0000;
        addr_mem_r[i] <= {AW{1'b0}};
      end
    end else if (push_s) begin
      data_mem_r[wr_ptr_r] <= mem_rdata;
      addr_mem_r[wr_ptr_r] <= req_addr_r;
    end else begin
      data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
      addr_mem_r[wr_ptr_r] <= addr_mem_r[wr_ptr_r];
    end
  end

`ifdef FETCH_PERF_EN
  logic stall_inc_s;
  assign stall_inc_s = ((state_r == FETCH) && mem_req_s && !mem_gnt) || full_s;

  // Saturating count of fetch stall cycles (grant wait or FIFO full).
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      perf_stall <= 32'h0000_0000;
    end else if (stall_inc_s && (perf_stall != 32'hFFFF_FFFF)) begin
      perf_stall <= perf_stall + 32'd1;
    end else begin
      perf_stall <= perf_stall;
    end
  end

  // Saturating count of redirect pulses.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      perf_flush <= 32'h0000_0000;
    end else if (redirect && (perf_flush != 32'hFFFF_FFFF)) begin
      perf_flush <= perf_flush + 32'd1;
    end else begin
      perf_flush <= perf_flush;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (DEPTH=4, AW=32).
// Inputs change just after the falling edge; outputs are checked 1 time unit
// later, well away from the rising edge.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        RST;
  logic [31:0] IADDR;
  logic [1:0]  pc_ctrl;
  logic [31:0] pc_jump;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_addr;
  logic        instr_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .RST(RST), .IADDR(IADDR), .pc_ctrl(pc_ctrl), .pc_jump(pc_jump),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_addr(instr_addr),
`ifdef FETCH_PERF_EN
    .perf_stall(perf_stall), .perf_flush(perf_flush),
`endif
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b0; IADDR = 32'd0; redirect = 1'b0; redirect_addr = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; instr_ready = 1'b0;
    next_cycle();
    next_cycle();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    RST = 1'b0; IADDR = 32'd0; redirect = 1'b0; redirect_addr = 32'd0;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'd0; instr_ready = 1'b1;
    next_cycle();
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
    checks++; if (pc_ctrl !== 2'b10) begin errors++; $display("FAIL reset_pc_ctrl: got %b want 10", pc_ctrl); end
    checks++; if (pc_jump !== 32'd0) begin errors++; $display("FAIL reset_pc_jump: got %h want 0", pc_jump); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_stall !== 32'd0 || perf_flush !== 32'd0) begin errors++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_stall, perf_flush); end
`endif
    next_cycle();
    RST = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    mem_gnt = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IADDR = i; mem_rvalid = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(i) || pc_ctrl !== 2'b00) begin errors++; $display("FAIL stream_grant%0d: got req=%b addr=%h ctrl=%b want 1/%h/00", i, mem_req, mem_addr, pc_ctrl, i); end
      if (i > 0) begin
        checks++; if (instr_valid !== 1'b1 || instr_addr !== 32'(i - 1) || instr_data !== (32'hC0DE_0000 | 32'(i - 1))) begin errors++; $display("FAIL stream_head%0d: got v=%b a=%h d=%h want 1/%h/%h", i, instr_valid, instr_addr, instr_data, i - 1, 32'hC0DE_0000 | 32'(i - 1)); end
      end
      next_cycle();
      IADDR = i + 1; mem_rvalid = 1'b1; mem_rdata = 32'hC0DE_0000 | 32'(i);
      #1;
      checks++; if (mem_req !== 1'b0 || pc_ctrl !== 2'b10 || instr_valid !== 1'b0) begin errors++; $display("FAIL stream_wait%0d: got req=%b ctrl=%b v=%b want 0/10/0", i, mem_req, pc_ctrl, instr_valid); end
      next_cycle();
    end
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 32'd3 || instr_data !== 32'hC0DE_0003 || pc_ctrl !== 2'b10) begin errors++; $display("FAIL stream_last: got v=%b a=%h d=%h ctrl=%b want 1/3/c0de0003/10", instr_valid, instr_addr, instr_data, pc_ctrl); end
    next_cycle();
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b want 0", instr_valid); end
  endtask

  task automatic test_full();
    do_reset();
    mem_gnt = 1'b1; instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      IADDR = i; mem_rvalid = 1'b0;
      next_cycle();
      IADDR = i + 1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_0000 | 32'(i);
      next_cycle();
    end
    mem_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (mem_req !== 1'b0 || pc_ctrl !== 2'b10 || instr_valid !== 1'b1 || instr_addr !== 32'd0) begin errors++; $display("FAIL full_hold%0d: got req=%b ctrl=%b v=%b a=%h want 0/10/1/0", k, mem_req, pc_ctrl, instr_valid, instr_addr); end
      next_cycle();
    end
    instr_ready = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || pc_ctrl !== 2'b10) begin errors++; $display("FAIL full_pop_cycle: got req=%b ctrl=%b want 0/10", mem_req, pc_ctrl); end
    next_cycle();
    instr_ready = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd4 || pc_ctrl !== 2'b00 || instr_addr !== 32'd1 || instr_data !== 32'h1111_0001) begin errors++; $display("FAIL full_resume: got req=%b addr=%h ctrl=%b a=%h d=%h want 1/4/00/1/11110001", mem_req, mem_addr, pc_ctrl, instr_addr, instr_data); end
    next_cycle();
  endtask

  task automatic test_gnt_stall();
    do_reset();
    IADDR = 32'd8; mem_gnt = 1'b0; instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd8 || pc_ctrl !== 2'b10) begin errors++; $display("FAIL stall%0d: got req=%b addr=%h ctrl=%b want 1/8/10", k, mem_req, mem_addr, pc_ctrl); end
      next_cycle();
    end
    mem_gnt = 1'b1;
    #1;
    checks++; if (pc_ctrl !== 2'b00) begin errors++; $display("FAIL stall_grant: got %b want 00", pc_ctrl); end
    next_cycle();
    IADDR = 32'd9; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hABCD_0008;
    next_cycle();
    mem_rvalid = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 32'd8 || instr_data !== 32'hABCD_0008) begin errors++; $display("FAIL stall_data: got v=%b a=%h d=%h want 1/8/abcd0008", instr_valid, instr_addr, instr_data); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_stall !== 32'd5) begin errors++; $display("FAIL stall_perf: got %0d want 5", perf_stall); end
`endif
    next_cycle();
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_gnt = 1'b1; instr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      IADDR = i; mem_rvalid = 1'b0;
      next_cycle();
      IADDR = i + 1; mem_rvalid = 1'b1; mem_rdata = 32'h2222_0000 | 32'(i);
      next_cycle();
    end
    IADDR = 32'd2; mem_rvalid = 1'b0;
    next_cycle();
    IADDR = 32'd3; redirect = 1'b1; redirect_addr = 32'h40;
    #1;
    checks++; if (pc_ctrl !== 2'b01 || pc_jump !== 32'h40 || mem_req !== 1'b0 || instr_valid !== 1'b1) begin errors++; $display("FAIL redir_cycle: got ctrl=%b jump=%h req=%b v=%b want 01/40/0/1", pc_ctrl, pc_jump, mem_req, instr_valid); end
    next_cycle();
    redirect = 1'b0; IADDR = 32'h40;
    #1;
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || pc_ctrl !== 2'b10) begin errors++; $display("FAIL redir_flush: got v=%b req=%b ctrl=%b want 0/0/10", instr_valid, mem_req, pc_ctrl); end
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    next_cycle();
    mem_rvalid = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h40 || pc_ctrl !== 2'b00) begin errors++; $display("FAIL redir_refetch: got v=%b req=%b addr=%h ctrl=%b want 0/1/40/00", instr_valid, mem_req, mem_addr, pc_ctrl); end
    next_cycle();
    IADDR = 32'h41; mem_rvalid = 1'b1; mem_rdata = 32'h4040_4040; mem_gnt = 1'b0;
    next_cycle();
    mem_rvalid = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 32'h40 || instr_data !== 32'h4040_4040) begin errors++; $display("FAIL redir_target: got v=%b a=%h d=%h want 1/40/40404040", instr_valid, instr_addr, instr_data); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_flush !== 32'd1) begin errors++; $display("FAIL redir_perf: got %0d want 1", perf_flush); end
`endif
    next_cycle();
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    mem_gnt = 1'b1; instr_ready = 1'b0; IADDR = 32'd0;
    next_cycle();
    IADDR = 32'd1; mem_rvalid = 1'b1; mem_rdata = 32'h3333_0000;
    next_cycle();
    mem_rvalid = 1'b0;
    next_cycle();
    IADDR = 32'd2; mem_rvalid = 1'b1; mem_rdata = 32'h3333_0001;
    redirect = 1'b1; redirect_addr = 32'h80; instr_ready = 1'b1;
    #1;
    checks++; if (pc_ctrl !== 2'b01 || pc_jump !== 32'h80 || instr_valid !== 1'b1) begin errors++; $display("FAIL rr_cycle: got ctrl=%b jump=%h v=%b want 01/80/1", pc_ctrl, pc_jump, instr_valid); end
    next_cycle();
    redirect = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0; instr_ready = 1'b0; IADDR = 32'h80;
    #1;
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h80 || pc_ctrl !== 2'b10) begin errors++; $display("FAIL rr_after: got v=%b req=%b addr=%h ctrl=%b want 0/1/80/10", instr_valid, mem_req, mem_addr, pc_ctrl); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_gnt = 1'b1; instr_ready = 1'b0; IADDR = 32'd0;
    next_cycle();
    IADDR = 32'd1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_0000;
    next_cycle();
    mem_rvalid = 1'b0;
    next_cycle();
    IADDR = 32'd2; mem_gnt = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || pc_ctrl !== 2'b10) begin errors++; $display("FAIL arst_immediate: got v=%b req=%b ctrl=%b want 0/0/10", instr_valid, mem_req, pc_ctrl); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_stall !== 32'd0 || perf_flush !== 32'd0) begin errors++; $display("FAIL arst_perf: got %h/%h want 0/0", perf_stall, perf_flush); end
`endif
    next_cycle();
    RST = 1'b1; IADDR = 32'h10; mem_gnt = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || pc_ctrl !== 2'b00 || instr_valid !== 1'b0) begin errors++; $display("FAIL arst_restart: got req=%b addr=%h ctrl=%b v=%b want 1/10/00/0", mem_req, mem_addr, pc_ctrl, instr_valid); end
    next_cycle();
    IADDR = 32'h11; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h6666_0010;
    next_cycle();
    mem_rvalid = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 32'h10 || instr_data !== 32'h6666_0010) begin errors++; $display("FAIL arst_data: got v=%b a=%h d=%h want 1/10/66660010", instr_valid, instr_addr, instr_data); end
    next_cycle();
  endtask

  initial begin
    RST = 1'b0; IADDR = 32'd0; redirect = 1'b0; redirect_addr = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_gnt_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer end of the program-counter interface.
- Takes the current instruction address (IADDR) from the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO for decode.
- Drives the PC's 2-bit control back: advance, jump or hold, so the PC only moves when a fetch is accepted or a redirect occurs.

Parameters:
- DEPTH, 4: instruction FIFO entries; power of two, at least 2.
- AW, 32: address width; must match the PC.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset; all state clears immediately while low.
- IADDR  in  AW  current PC value (word address).
- pc_ctrl  out  2  to PC: 2'b00 increment, 2'b01 load pc_jump, 2'b10 hold.
- pc_jump  out  AW  jump target for the PC; equals redirect_addr.
- redirect  in  1  taken branch/jump from execute; single-cycle pulse.
- redirect_addr  in  AW  target address, valid with redirect.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  AW  read address; equals IADDR while mem_req is high.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid; 1+ cycles after gnt, exactly one per gnt.
- mem_rdata  in  32  read data.
- instr_valid  out  1  FIFO head valid (FIFO not empty).
- instr_data  out  32  FIFO head instruction.
- instr_addr  out  AW  address of the FIFO head instruction.
- instr_ready  in  1  decode consumes the head this cycle when instr_valid is high.

Behaviour:
- FSM states: FETCH, WAIT_RSP, FLUSH. Reset state is FETCH.
- Reset:
  - FIFO empty, count 0, instr_valid 0, mem_req 0.
  - pc_ctrl 2'b10, pc_jump 0, stored request address 0.
- Maximum outstanding memory requests: 1.
- FETCH:
  - mem_req = !redirect && (count < DEPTH).
  - On mem_req && mem_gnt: latch req_addr = IADDR, set pc_ctrl = 2'b00 that cycle, go to WAIT_RSP.
  - Otherwise pc_ctrl = 2'b10.
- WAIT_RSP:
  - mem_req = 0.
  - On mem_rvalid: push {req_addr, mem_rdata} into the FIFO, go to FETCH.
  - Space is guaranteed because the slot was reserved at issue.
  - rvalid and gnt in the same cycle is not possible; one outstanding request maximum.
- FLUSH:
  - Entered when redirect arrives while in WAIT_RSP without mem_rvalid.
  - The next mem_rvalid is discarded, then go to FETCH.
  - mem_req = 0 while in FLUSH.
- Redirect has highest priority in any state:
  - pc_ctrl = 2'b01, pc_jump = redirect_addr, mem_req forced 0.
  - FIFO cleared on the same edge (count 0, pointers 0); a concurrent pop or push is ignored.
  - Next state: FETCH if in FETCH, or if in WAIT_RSP with mem_rvalid the same cycle (data dropped); FLUSH if WAIT_RSP without rvalid; stays FLUSH if already in FLUSH.
  - First fetch from the new target occurs no earlier than the cycle after redirect.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pop on an empty FIFO is ignored.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Throughput: at most one instruction per 2 cycles with 1-cycle memory latency.
- Fetch latency: IADDR at grant to instr_valid is rvalid cycle + 1.
- FIFO full (count == DEPTH): mem_req low, pc_ctrl 2'b10, PC holds.
- RST low mid-transaction: everything clears asynchronously. A late mem_rvalid after reset release is not expected; the memory is reset by the same RST.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, two extra outputs are present:
  - perf_stall  out  32: counts cycles in FETCH with mem_req high and mem_gnt low, plus cycles with count == DEPTH.
  - perf_flush  out  32: counts redirect pulses.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with IADDR=0, gnt always 1, rvalid 1 cycle after gnt, instr_ready=1 -> instr_addr sequence 0,1,2,3 with matching mem_rdata; pc_ctrl=00 on each grant cycle, 10 otherwise.
- instr_ready=0, DEPTH=4 -> after 4 pushes mem_req stays 0 and pc_ctrl=10; raise ready -> fetch resumes at IADDR=4.
- mem_gnt held low for 5 cycles -> mem_req stays high, mem_addr stable, pc_ctrl=10; PC does not advance.
- redirect to 0x40 while in WAIT_RSP with 2 entries buffered -> FIFO empties next edge, pc_ctrl=01 and pc_jump=0x40 in that cycle, the returning rvalid is dropped, next instr_addr=0x40.
- redirect in the same cycle as mem_rvalid and instr_ready -> nothing pushed or popped, FIFO empty, state FETCH.
- RST low for 1 cycle mid WAIT_RSP -> instr_valid=0, mem_req=0, pc_ctrl=10 immediately (asynchronous); normal fetch after release. With FETCH_PERF_EN, perf counters read 0.
